// File: rtl/serial_add_ctrl_if.sv
// Requester-side bundle for serial_add_ctrl: operation request plus result.
// The sub select exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, op_a, op_b, cin,
    input  busy, done, sum, carry
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, op_a, op_b, cin,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller sharing one external full_adder cell, LSB first.
// Define SERIAL_ADD_SUB_EN to add the subtract select (two's complement via ~b, cin=1).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   req,
  output logic               fa_a,
  output logic               fa_b,
  output logic               fa_cin,
  input  logic               fa_sum,
  input  logic               fa_carry
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // New sum bit enters at the MSB so the LSB-first stream lands in place.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_shift = fa_sum;
    end else begin : g_acc_wn
      assign acc_shift = {fa_sum, acc_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_ADD_SUB_EN
  assign b_load = req.sub ? ~req.op_b : req.op_b;
  assign c_load = req.sub ? 1'b1 : req.cin;
`else
  assign b_load = req.op_b;
  assign c_load = req.cin;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_cin  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.start) begin
          a_sh_d  = req.op_a;
          b_sh_d  = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        fa_a   = a_sh_q[0];
        fa_b   = b_sh_q[0];
        fa_cin = c_q;
        acc_d  = acc_shift;
        c_d    = fa_carry;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = acc_shift;
          carry_d = fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign req.busy  = (state_q == RUN);
  assign req.done  = (state_q == DONE);
  assign req.sum   = sum_q;
  assign req.carry = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder.
// Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fa_a, fa_b, fa_cin, fa_sum, fa_carry;
  int   checks = 0;
  int   errors = 0;
  logic sub_v  = 1'b0;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) intf ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (intf.slave),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_sum   (fa_sum),
    .fa_carry (fa_carry)
  );

  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
`ifdef SERIAL_ADD_SUB_EN
  assign intf.sub = sub_v;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one op at the current negedge and follows it to the cycle after done.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb,
                        input logic [7:0] exp_sum, input logic exp_carry,
                        input int restart_at,
                        output logic [7:0] fa_a_seq, output logic [7:0] fa_b_seq);
    int n;
    int dones;
    intf.op_a  = a;
    intf.op_b  = b;
    intf.cin   = ci;
    sub_v      = sb;
    intf.start = 1'b1;
    @(negedge clk);
    intf.start = 1'b0;
    intf.op_a  = 8'($urandom);
    intf.op_b  = 8'($urandom);
    intf.cin   = 1'($urandom);
    n = 0;
    fa_a_seq = '0;
    fa_b_seq = '0;
    while (intf.busy && n < 20) begin
      if (n < 8) begin
        fa_a_seq[n] = fa_a;
        fa_b_seq[n] = fa_b;
      end
      n++;
      intf.start = (restart_at != 0 && n == restart_at);
      @(negedge clk);
    end
    intf.start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'd8);
    check({tag, "_done"}, 32'(intf.done), 32'd1);
    check({tag, "_sum"}, 32'(intf.sum), 32'(exp_sum));
    check({tag, "_carry"}, 32'(intf.carry), 32'(exp_carry));
    check({tag, "_fa_idle"}, 32'({fa_a, fa_b, fa_cin}), 32'd0);
    $display("op %s: a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h carry=%0d", tag, a, b, ci, sb,
             intf.sum, intf.carry);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(intf.done), 32'd0);
    if (restart_at != 0) begin
      dones = 0;
      repeat (12) begin
        @(negedge clk);
        if (intf.done || intf.busy) dones++;
      end
      check({tag, "_no_extra_op"}, 32'(dones), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] sa, sb_seq;
    int extra;
    intf.start = 1'b0;
    intf.op_a  = '0;
    intf.op_b  = '0;
    intf.cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(intf.busy), 32'd0);
    check("rst_done", 32'(intf.done), 32'd0);
    check("rst_sum", 32'(intf.sum), 32'd0);
    check("rst_carry", 32'(intf.carry), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, sa, sb_seq);
    run_op("ff_p1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0, sa, sb_seq);
    check("ff_p1_fa_a_seq", 32'(sa), 32'h0000_00FF);
    check("ff_p1_fa_b_seq", 32'(sb_seq), 32'h0000_0001);
    run_op("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 3, sa, sb_seq);

    // Reset at busy cycle 4 of 0x3C+0x0F: result dropped, registers cleared.
    intf.op_a  = 8'h3C;
    intf.op_b  = 8'h0F;
    intf.cin   = 1'b0;
    intf.start = 1'b1;
    @(negedge clk);
    intf.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", 32'(intf.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(intf.busy), 32'd0);
    check("mid_rst_done", 32'(intf.done), 32'd0);
    check("mid_rst_sum", 32'(intf.sum), 32'd0);
    check("mid_rst_carry", 32'(intf.carry), 32'd0);
    check("mid_rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (intf.done || intf.busy) extra++;
    end
    check("mid_rst_no_done", 32'(extra), 32'd0);
    $display("op mid_rst: a=3c b=0f aborted -> sum=%02h carry=%0d", intf.sum, intf.carry);

    run_op("3c_0f", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 0, sa, sb_seq);
    run_op("b2b_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 0, sa, sb_seq);
    run_op("b2b_01_02", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 0, sa, sb_seq);
    repeat (3) @(negedge clk);
    check("hold_sum", 32'(intf.sum), 32'h03);
`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 0, sa, sb_seq);
    run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 0, sa, sb_seq);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
